// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the arbiter's requester-side and output-side handshake signals.
// master = the arbiter, slave = the requesters plus the downstream datapath.
interface stream_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int SRC_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_last;
    logic [SRC_WIDTH-1:0]          out_src;
    logic [NUM_REQ-1:0]            grant;
    logic                          burst_cut;

    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_src, grant, burst_cut
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_src, grant, burst_cut
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter: atomic bursts closed by req_last or a MAX_BURST cap,
// one IDLE arbitration cycle per grant, single registered output stage.
module stream_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input logic                 clk,
    input logic                 reset,
    stream_rr_arbiter_if.master bus
);
    localparam int SRC_WIDTH = $clog2(NUM_REQ);
    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [CNT_WIDTH-1:0] CAP_PREV = CNT_WIDTH'(MAX_BURST - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    state_t                state_next;
    logic [SRC_WIDTH-1:0]  grant_idx;
    logic [SRC_WIDTH-1:0]  last_idx;
    logic [SRC_WIDTH-1:0]  pick_idx;
    logic                  pick_found;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic                  can_load;
    logic                  accept;
    logic                  beat_last;
    logic                  at_cap;
    logic                  release_any;
    logic                  release_cap;
    logic [DATA_WIDTH-1:0] beat_data;

    assign can_load    = !bus.out_valid || bus.out_ready;
    assign bus.req_ready = (state == BUSY && can_load) ? bus.grant : '0;

    // Only the granted lane is ever selected; other lanes' data is never sampled.
    assign beat_data   = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign beat_last   = bus.req_last[grant_idx];
    assign accept      = (state == BUSY) && bus.req_valid[grant_idx] && can_load;
    assign at_cap      = (beat_cnt == CAP_PREV);
    assign release_any = accept && (beat_last || at_cap);
    assign release_cap = accept && !beat_last && at_cap;

    // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_found && bus.req_valid[(int'(last_idx) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = SRC_WIDTH'((int'(last_idx) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found)  state_next = BUSY;
            BUSY:    if (release_any) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.grant     <= '0;
            grant_idx     <= '0;
            last_idx      <= SRC_WIDTH'(NUM_REQ - 1);
            beat_cnt      <= '0;
            bus.burst_cut <= 1'b0;
        end else begin
            state         <= state_next;
            bus.burst_cut <= release_cap;
            if (state == IDLE && pick_found) begin
                bus.grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                grant_idx <= pick_idx;
                beat_cnt  <= '0;
            end else if (release_any) begin
                bus.grant <= '0;
                last_idx  <= grant_idx;
                beat_cnt  <= '0;
            end else if (accept) begin
                beat_cnt  <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_src   <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= beat_data;
            bus.out_last  <= beat_last;
            bus.out_src   <= grant_idx;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares the single 8-bit `stream_in` ready/valid port of the sample datapath between `NUM_REQ` independent requesters. Requester bursts are granted atomically, bounded by `req_last` or a fairness cap. Beats pass through one registered output stage whose outputs drive `stream_in_valid` and `stream_in_data` directly. Back-pressure comes from the datapath's `stream_in_ready` via `out_ready`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 8: beat width; matches `stream_in_data`.
- `MAX_BURST`, default 16: maximum beats per grant, ≥1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input NUM_REQ: per-requester beat valid.
- `req_ready` output NUM_REQ: per-requester beat accept.
- `req_data` input NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` input NUM_REQ: final beat of the requester's burst.
- `out_valid` output 1: registered beat valid; drives `stream_in_valid`.
- `out_ready` input 1: downstream accept; driven from `stream_in_ready`.
- `out_data` output DATA_WIDTH: registered beat data.
- `out_last` output 1: registered copy of `req_last` for the beat.
- `out_src` output $clog2(NUM_REQ): index of the requester that supplied the beat.
- `grant` output NUM_REQ: one-hot current grant; all-zero when idle.
- `burst_cut` output 1: one-cycle pulse when a grant is released by the `MAX_BURST` cap.

## Operation
- **Reset values:** `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0, `grant`=0, `burst_cut`=0, `req_ready`=0.
  - Internal state: FSM=IDLE, beat counter=0, priority pointer `last_idx`=NUM_REQ-1, so requester 0 wins first.
- **Output register:** `can_load` = !out_valid || out_ready.
  - On a load: `out_data`/`out_last`/`out_src` take the granted requester's beat and `out_valid`=1.
  - If `out_ready` with no load: `out_valid`=0; data fields hold their value.
- **FSM IDLE:**
  - `req_ready`=0.
  - If any `req_valid`: pick the first asserted index searching from `last_idx`+1 upward, modulo NUM_REQ.
  - Register it into `grant`, clear the beat counter, go to BUSY.
  - No valid: stay in IDLE.
- **FSM BUSY (grant=g):**
  - `req_ready[g]` = can_load; all other `req_ready` bits 0.
  - A beat is accepted when req_valid[g] && req_ready[g]; each accepted beat increments the counter.
- **Release:** on an accepted beat with req_last[g]=1, or when the accepted beat is beat number MAX_BURST.
  - `last_idx`<=g, `grant`<=0, next state IDLE.
  - `burst_cut` pulses only for the cap case with req_last[g]=0.
  - last and cap in the same beat counts as a natural end: no pulse.
- **Granted requester deasserts valid mid-burst:** the grant is held indefinitely; no timeout and no preemption.
- **Non-granted requesters:** their valid is ignored and their data is never sampled.
- **Counter width:** $clog2(MAX_BURST+1); it never exceeds MAX_BURST.
- **Reset mid-burst:** all state clears asynchronously and `out_valid` drops immediately. The partial burst is abandoned; after release, arbitration restarts at requester 0.

## Timing
- Arbitration costs one IDLE cycle per grant.
  - Request visible at edge N → `grant` set after edge N+1.
  - `req_ready` high in the following cycle if `can_load`.
  - Beat visible on `out_*` after the accepting edge.
- **Within a burst:** 1 beat/cycle while `out_ready`=1. The path `out_ready`→`req_ready` is combinational.
- **Between bursts:** exactly one bubble cycle (the IDLE cycle), even if the next requester is already valid.
- A valid asserted during the release cycle is arbitrated in the following IDLE cycle; the pointer has already advanced past g.
- **Stall:** `out_ready`=0 with `out_valid`=1 holds all `out_*` stable and forces `req_ready`=0.

## Test plan
- **Reset / first grant:** all four requesters valid with 1-beat bursts (last=1), data 0x10,0x11,0x12,0x13 → `out_src` sequence 0,1,2,3,0.
  - `out_data` matches; each beat is separated by one bubble.
- **Burst atomicity:** requester 2 sends 5 beats 0xA0..0xA4 (last on the 5th) while requester 1 is valid → five consecutive `out_src`=2 beats, then requester 1 is granted.
- **Fairness cap:** MAX_BURST=4, requester 0 streams 10 beats with last only on the 10th while requester 3 is waiting.
  - Required: 4 beats from 0, `burst_cut` pulse, then requester 3, then requester 0 resumes.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles mid-burst → `out_data` stable, `req_ready[g]`=0, no beat lost or duplicated; the downstream receives the full sequence in order.
- **Reset mid-burst:** assert `reset` while beat 2 of 5 is in the output register → `out_valid`=0 within the same cycle.
  - After deassert, requester 0 wins even if requester 3 held the previous grant.
- **Idle gap in grant:** the granted requester drops valid for 6 cycles mid-burst → grant held, other requesters get no `req_ready`, and the burst completes on resume.
